// File: rtl/inport_conditioner.sv
// IN.PORT / Stop input stage: synchronises board switches and buttons, debounces the buttons,
// and holds a captured inport word behind a valid/ack handshake plus a toggling Stop level.

module inport_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH       = 20
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pressed,
  output logic o_event
);

  localparam logic [1:0] ST_RELEASED    = 2'd0;
  localparam logic [1:0] ST_ARM_PRESS   = 2'd1;
  localparam logic [1:0] ST_PRESSED     = 2'd2;
  localparam logic [1:0] ST_ARM_RELEASE = 2'd3;

  localparam logic [CNT_WIDTH-1:0] L_DEB  = CNT_WIDTH'(DEBOUNCE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] L_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] L_ZERO = CNT_WIDTH'(0);

  logic [1:0]           r_state;
  logic [1:0]           w_state_next;
  logic [CNT_WIDTH-1:0] r_count;
  logic [CNT_WIDTH-1:0] w_count_next;
  logic [CNT_WIDTH-1:0] w_count_inc;
  logic                 w_event;

  assign w_count_inc = r_count + L_ONE;
  assign o_event     = w_event;

  // Next-state logic; the press event fires on the transition into PRESSED
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_event      = 1'b0;
    case (r_state)
      ST_RELEASED: begin
        if (i_pressed) begin
          if (L_DEB <= L_ONE) begin
            w_state_next = ST_PRESSED;
            w_count_next = L_ZERO;
            w_event      = 1'b1;
          end else begin
            w_state_next = ST_ARM_PRESS;
            w_count_next = L_ONE;
          end
        end else begin
          w_state_next = ST_RELEASED;
        end
      end
      ST_ARM_PRESS: begin
        if (!i_pressed) begin
          w_state_next = ST_RELEASED;
          w_count_next = L_ZERO;
        end else if (w_count_inc == L_DEB) begin
          w_state_next = ST_PRESSED;
          w_count_next = L_ZERO;
          w_event      = 1'b1;
        end else begin
          w_count_next = w_count_inc;
        end
      end
      ST_PRESSED: begin
        if (!i_pressed) begin
          if (L_DEB <= L_ONE) begin
            w_state_next = ST_RELEASED;
            w_count_next = L_ZERO;
          end else begin
            w_state_next = ST_ARM_RELEASE;
            w_count_next = L_ONE;
          end
        end else begin
          w_state_next = ST_PRESSED;
        end
      end
      ST_ARM_RELEASE: begin
        if (i_pressed) begin
          w_state_next = ST_PRESSED;
          w_count_next = L_ZERO;
        end else if (w_count_inc == L_DEB) begin
          w_state_next = ST_RELEASED;
          w_count_next = L_ZERO;
        end else begin
          w_count_next = w_count_inc;
        end
      end
      default: begin
        w_state_next = ST_RELEASED;
        w_count_next = L_ZERO;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_RELEASED;
      r_count <= L_ZERO;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

endmodule

module inport_conditioner #(
  parameter int SW_WIDTH        = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH       = 20
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [SW_WIDTH-1:0] switches,
  input  logic                loadButton,
  input  logic                stopButton,
  input  logic                inportAck,
  output logic [31:0]         inportInput,
  output logic                inportValid,
  output logic                inportOvr,
  output logic                Stop
);

  logic [SW_WIDTH-1:0] r_sw_meta;
  logic [SW_WIDTH-1:0] r_sw_sync;
  logic                r_ld_meta;
  logic                r_ld_sync;
  logic                r_st_meta;
  logic                r_st_sync;
  logic                w_ld_evt;
  logic                w_st_evt;

  // Two-flop synchronisers; buttons idle high so they reset to the released level
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
      r_ld_meta <= 1'b1;
      r_ld_sync <= 1'b1;
      r_st_meta <= 1'b1;
      r_st_sync <= 1'b1;
    end else begin
      r_sw_meta <= switches;
      r_sw_sync <= r_sw_meta;
      r_ld_meta <= loadButton;
      r_ld_sync <= r_ld_meta;
      r_st_meta <= stopButton;
      r_st_sync <= r_st_meta;
    end
  end

  inport_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_WIDTH       (CNT_WIDTH)
  ) u_load_db (
    .i_clk     (Clock),
    .i_rst_n   (Reset),
    .i_pressed (~r_ld_sync),
    .o_event   (w_ld_evt)
  );

  inport_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_WIDTH       (CNT_WIDTH)
  ) u_stop_db (
    .i_clk     (Clock),
    .i_rst_n   (Reset),
    .i_pressed (~r_st_sync),
    .o_event   (w_st_evt)
  );

  // Capture/handshake: a load beats a simultaneous ack, and an ack with it clears the overrun
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      inportInput <= 32'h0000_0000;
      inportValid <= 1'b0;
      inportOvr   <= 1'b0;
      Stop        <= 1'b0;
    end else begin
      if (w_ld_evt) begin
        inportInput <= 32'(r_sw_sync);
        inportValid <= 1'b1;
        inportOvr   <= inportValid & ~inportAck;
      end else if (inportAck && inportValid) begin
        inportValid <= 1'b0;
        inportOvr   <= 1'b0;
      end else begin
        inportValid <= inportValid;
        inportOvr   <= inportOvr;
      end
      if (w_st_evt) begin
        Stop <= ~Stop;
      end else begin
        Stop <= Stop;
      end
    end
  end

endmodule

// File: tb/tb_inport_conditioner.sv
// Scoreboard bench for inport_conditioner: expectations are queued with their due edge
// when stimulus is driven and compared by a monitor just after that edge.

module tb_inport_conditioner;

  logic        Clock;
  logic        Reset;
  logic [7:0]  switches;
  logic        loadButton;
  logic        stopButton;
  logic        inportAck;
  logic [31:0] inportInput;
  logic        inportValid;
  logic        inportOvr;
  logic        Stop;

  inport_conditioner #(
    .SW_WIDTH        (8),
    .DEBOUNCE_CYCLES (4),
    .CNT_WIDTH       (20)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .switches    (switches),
    .loadButton  (loadButton),
    .stopButton  (stopButton),
    .inportAck   (inportAck),
    .inportInput (inportInput),
    .inportValid (inportValid),
    .inportOvr   (inportOvr),
    .Stop        (Stop)
  );

  typedef struct {
    int          due;
    string       tag;
    logic [31:0] in;
    logic        v;
    logic        o;
    logic        s;
  } exp_t;

  exp_t        sb[$];
  int          cyc      = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_in     = 32'h0;
  logic        m_valid  = 1'b0;
  logic        m_ovr    = 1'b0;
  logic        m_stop   = 1'b0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clock);
      #2;
    end
  endtask

  task automatic push(input int due, input string tag);
    exp_t e;
    e.due = due; e.tag = tag; e.in = m_in; e.v = m_valid; e.o = m_ovr; e.s = m_stop;
    sb.push_back(e);
  endtask

  // Monitor: sample 1 ns after each rising edge and retire every due expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge Clock);
      cyc = cyc + 1;
      #1;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        check({e.tag, "_due"}, 32'(cyc), 32'(e.due));
        check({e.tag, "_in"},  inportInput, e.in);
        check({e.tag, "_val"}, 32'(inportValid), 32'(e.v));
        check({e.tag, "_ovr"}, 32'(inportOvr), 32'(e.o));
        check({e.tag, "_stop"}, 32'(Stop), 32'(e.s));
      end
    end
  end

  task automatic load_press(input logic [7:0] sw_val, input bit with_ack, input string tag);
    int t0;
    switches = sw_val;
    tick(3);
    t0 = cyc;
    push(t0 + 5, {tag, "_pre"});
    m_ovr   = with_ack ? 1'b0 : m_valid;
    m_in    = {24'h0, sw_val};
    m_valid = 1'b1;
    push(t0 + 6, {tag, "_cap"});
    push(t0 + 16, {tag, "_hold"});
    loadButton = 1'b0;
    tick(5);
    if (with_ack) inportAck = 1'b1;
    tick(1);
    inportAck = 1'b0;
    tick(10);
    loadButton = 1'b1;
    tick(8);
  endtask

  task automatic ack_pulse(input string tag);
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
    push(cyc + 1, tag);
    inportAck = 1'b1;
    tick(1);
    inportAck = 1'b0;
    tick(2);
  endtask

  task automatic stop_press(input string tag);
    int t0;
    t0 = cyc;
    push(t0 + 5, {tag, "_pre"});
    m_stop = ~m_stop;
    push(t0 + 6, {tag, "_tog"});
    stopButton = 1'b0;
    tick(10);
    stopButton = 1'b1;
    tick(8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    Reset = 1'b0; switches = 8'h00; loadButton = 1'b1; stopButton = 1'b1; inportAck = 1'b0;
    tick(3);
    Reset = 1'b1;
    tick(2);
    check("rst_in",   inportInput, 32'h0);
    check("rst_val",  32'(inportValid), 32'h0);
    check("rst_ovr",  32'(inportOvr), 32'h0);
    check("rst_stop", 32'(Stop), 32'h0);

    load_press(8'hA5, 1'b0, "clean");
    ack_pulse("ack_clean");
    ack_pulse("ack_idle");

    // Bounce: 3 low, 1 high, 6 low; only the second burst qualifies
    switches = 8'h3C;
    tick(3);
    t0 = cyc;
    push(t0 + 6, "bnc_first");
    push(t0 + 9, "bnc_pre");
    m_ovr = m_valid; m_in = 32'h3C; m_valid = 1'b1;
    push(t0 + 10, "bnc_cap");
    loadButton = 1'b0; tick(3);
    loadButton = 1'b1; tick(1);
    loadButton = 1'b0; tick(6);
    loadButton = 1'b1; tick(10);
    ack_pulse("ack_bnc");

    load_press(8'h11, 1'b0, "ovr1");
    load_press(8'h22, 1'b0, "ovr2");
    ack_pulse("ack_ovr");

    load_press(8'h44, 1'b0, "pre_ackld");
    load_press(8'h55, 1'b1, "ackld");

    stop_press("stop1");
    stop_press("stop2");
    stop_press("stop3");

    t0 = cyc;
    push(t0 + 8, "glitch");
    stopButton = 1'b0; tick(2);
    stopButton = 1'b1; tick(10);

    // Asynchronous reset in the middle of a load debounce
    switches = 8'h99;
    tick(3);
    loadButton = 1'b0;
    tick(4);
    #3 Reset = 1'b0;
    #1;
    check("arst_in",   inportInput, 32'h0);
    check("arst_val",  32'(inportValid), 32'h0);
    check("arst_ovr",  32'(inportOvr), 32'h0);
    check("arst_stop", 32'(Stop), 32'h0);
    m_in = 32'h0; m_valid = 1'b0; m_ovr = 1'b0; m_stop = 1'b0;
    loadButton = 1'b1;
    tick(2);
    Reset = 1'b1;
    push(cyc + 10, "no_stale");
    tick(12);

    // Both buttons qualified in the same cycle
    load_press(8'h66, 1'b0, "pre_both");
    switches = 8'h77;
    tick(3);
    t0 = cyc;
    push(t0 + 5, "both_pre");
    m_ovr = m_valid; m_in = 32'h77; m_valid = 1'b1; m_stop = ~m_stop;
    push(t0 + 6, "both_cap");
    loadButton = 1'b0; stopButton = 1'b0;
    tick(10);
    loadButton = 1'b1; stopButton = 1'b1;
    tick(8);

    check("sb_drain", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
